// File: rtl/systolic_feeder.sv
// Purpose : input-side skew generator for the 2x2 systolic MMU; sequences one tile of
//           vec_count vectors per start, skews row 1 by one cycle, drains, pulses done.
// Latency : row 0 registered one cycle after accept; row 1 one cycle after row 0.
// Backpr. : in_ready is high only in FEED while vectors remain; in_valid is never
//           required to be held and does not affect in_ready.
// Ports   : clk, reset (async, active-high), clear (sync abort), start/vec_count (tile
//           launch), in_valid/in_ready/in_row0/in_row1 (upstream vector handshake),
//           mmu_row{0,1}_out/_valid (skewed MMU row drive), busy, done.
module systolic_feeder #(
  parameter int DATA_W       = 8,
  parameter int CNT_W        = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     start,
  input  logic [CNT_W-1:0]         vec_count,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_row0,
  input  logic signed [DATA_W-1:0] in_row1,
  output logic signed [DATA_W-1:0] mmu_row0_out,
  output logic signed [DATA_W-1:0] mmu_row1_out,
  output logic                     mmu_row0_valid,
  output logic                     mmu_row1_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_SKEW  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [CNT_W-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]         acc_inc;
  logic [DRN_W-1:0]         drain_q, drain_d;
  logic                     done_q, done_d;
  logic signed [DATA_W-1:0] row0_q, row0_d;
  logic                     row0_vld_q, row0_vld_d;
  logic signed [DATA_W-1:0] stg_q, stg_d;
  logic                     stg_vld_q, stg_vld_d;
  logic signed [DATA_W-1:0] row1_q, row1_d;
  logic                     row1_vld_q, row1_vld_d;
  logic                     accept;

  // Ready depends only on state and counters so upstream may compute valid from it.
  assign in_ready = (state_q == S_FEED) && (acc_q < count_q);
  assign accept   = in_valid && in_ready;
  assign acc_inc  = acc_q + CNT_W'(1);
  assign busy     = (state_q != S_IDLE);

  assign done           = done_q;
  assign mmu_row0_out   = row0_q;
  assign mmu_row0_valid = row0_vld_q;
  assign mmu_row1_out   = row1_q;
  assign mmu_row1_valid = row1_vld_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    drain_d = drain_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (vec_count != '0) begin
            count_d = vec_count;
            acc_d   = '0;
            state_d = S_FEED;
          end else begin
            // Empty tile: nothing to feed, report completion straight away.
            done_d = 1'b1;
          end
        end
      end
      S_FEED: begin
        if (accept) begin
          acc_d = acc_inc;
          if (acc_inc == count_q) state_d = S_SKEW;
        end
      end
      S_SKEW: begin
        // Last row-1 element leaves the skew stage on this edge.
        state_d = S_DRAIN;
        drain_d = DRN_INIT;
      end
      S_DRAIN: begin
        // done is registered, so it shows one cycle after the counter reaches zero.
        if (drain_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Non-accept cycles push zero/invalid bubbles so the wavefront stays aligned.
    row0_d     = accept ? in_row0 : '0;
    row0_vld_d = accept;
    stg_d      = accept ? in_row1 : '0;
    stg_vld_d  = accept;
    row1_d     = stg_q;
    row1_vld_d = stg_vld_q;

    if (clear) begin
      state_d    = S_IDLE;
      count_d    = '0;
      acc_d      = '0;
      drain_d    = '0;
      done_d     = 1'b0;
      row0_d     = '0;
      row0_vld_d = 1'b0;
      stg_d      = '0;
      stg_vld_d  = 1'b0;
      row1_d     = '0;
      row1_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      row0_q     <= '0;
      row0_vld_q <= 1'b0;
      stg_q      <= '0;
      stg_vld_q  <= 1'b0;
      row1_q     <= '0;
      row1_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      row0_q     <= row0_d;
      row0_vld_q <= row0_vld_d;
      stg_q      <= stg_d;
      stg_vld_q  <= stg_vld_d;
      row1_q     <= row1_d;
      row1_vld_q <= row1_vld_d;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Purpose : self-checking bench for systolic_feeder against a timing-formula model.
// Latency : n/a (testbench).
// Backpr. : drives in_valid with random bubbles; expects ready only while tile open.
module tb_systolic_feeder;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int D  = 3;

  logic clk = 1'b0;
  logic reset, clear, start, in_valid;
  logic [CW-1:0] vec_count;
  logic in_ready;
  logic signed [DW-1:0] in_row0, in_row1, r0, r1;
  logic r0v, r1v, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic signed [DW-1:0] q0[$];
  logic signed [DW-1:0] q1[$];

  systolic_feeder #(.DATA_W(DW), .CNT_W(CW), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .vec_count(vec_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_row0(in_row0), .in_row1(in_row1),
    .mmu_row0_out(r0), .mmu_row1_out(r1), .mmu_row0_valid(r0v), .mmu_row1_valid(r1v),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Runs one tile. Expectations come from the accept schedule: row 0 shows the vector
  // accepted on this edge, row 1 the one accepted on the previous edge, and done
  // appears 2+D edges after the last accept. bmode: 0 none, 1 random bubbles,
  // 2 single bubble in the second feed cycle. inj_at: loop step that pulses a stray start.
  task automatic run_tile(input int n, input int bmode, input int inj_at,
                          output int s_edge, output int obs_done, output int n_acc);
    int acc, done_edge;
    logic exp_rdy, v, acc_now, p_acc;
    logic signed [DW-1:0] a0, a1, p_r1;
    start = 1'b1; vec_count = CW'(n); in_valid = 1'b0;
    step();
    s_edge = cyc;
    start = 1'b0;
    acc = 0; done_edge = -1; obs_done = -1; p_acc = 1'b0; p_r1 = '0;
    for (int t = 0; t < 300; t++) begin
      exp_rdy = (acc < n);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
      end
      v = 1'b1;
      if (bmode == 1) v = ($urandom_range(0, 3) != 0);
      if (bmode == 2 && t == 1) v = 1'b0;
      if (!exp_rdy) v = 1'($urandom_range(0, 1));
      acc_now = v && exp_rdy;
      if (acc_now && q0.size() > 0) begin
        a0 = q0.pop_front(); a1 = q1.pop_front();
      end else begin
        a0 = DW'($urandom); a1 = DW'($urandom);
      end
      if (t == inj_at) begin start = 1'b1; vec_count = CW'(9); end
      else start = 1'b0;
      in_valid = v; in_row0 = a0; in_row1 = a1;
      step();
      if (acc_now) begin
        acc++;
        if (acc == n) done_edge = cyc + 2 + D;
      end
      if (done === 1'b1 && obs_done < 0) obs_done = cyc;
      checks++;
      if (r0v !== acc_now || r0 !== (acc_now ? a0 : DW'(0))) begin
        errors++; $display("FAIL row0 cyc=%0d got=%b/%0d exp=%b/%0d", cyc, r0v, r0, acc_now, acc_now ? a0 : DW'(0));
      end
      checks++;
      if (r1v !== p_acc || r1 !== p_r1) begin
        errors++; $display("FAIL row1 cyc=%0d got=%b/%0d exp=%b/%0d", cyc, r1v, r1, p_acc, p_r1);
      end
      checks++;
      if (done !== (cyc == done_edge)) begin
        errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, cyc == done_edge);
      end
      checks++;
      if (busy !== (done_edge < 0 || cyc < done_edge)) begin
        errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, done_edge < 0 || cyc < done_edge);
      end
      p_acc = acc_now;
      p_r1  = acc_now ? a1 : DW'(0);
      if (done_edge >= 0 && cyc == done_edge + 1) break;
    end
    in_valid = 1'b0; start = 1'b0;
    n_acc = acc;
    checks++;
    if (done_edge < 0 || cyc != done_edge + 1) begin
      errors++; $display("FAIL tile_timeout cyc=%0d got_done_edge=%0d exp_end=%0d", cyc, obs_done, done_edge + 1);
    end
  endtask

  task automatic test_reset();
    int s, od, na;
    reset = 1'b1; clear = 1'b0; start = 1'b0; in_valid = 1'b0; vec_count = '0;
    in_row0 = '0; in_row1 = '0;
    #2;
    checks++;
    if ({in_ready, busy, done, r0v, r1v} !== 5'b0 || r0 !== 0 || r1 !== 0) begin
      errors++; $display("FAIL reset_init got=%b%b%b%b%b r0=%0d r1=%0d exp=00000 0 0", in_ready, busy, done, r0v, r1v, r0, r1);
    end
    step(); step();
    reset = 1'b0;
    start = 1'b1; vec_count = CW'(4);
    step();
    start = 1'b0; in_valid = 1'b1; in_row0 = 8'sd5; in_row1 = 8'sd6;
    step(); step();
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy, done, r0v, r1v} !== 5'b0 || r0 !== 0 || r1 !== 0) begin
      errors++; $display("FAIL reset_mid got=%b%b%b%b%b r0=%0d r1=%0d exp=00000 0 0", in_ready, busy, done, r0v, r1v, r0, r1);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({in_ready, busy, done, r0v, r1v} !== 5'b0) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%b%b%b%b%b exp=00000", cyc, in_ready, busy, done, r0v, r1v);
      end
    end
    in_valid = 1'b0;
    s = 0; od = 0; na = 0;
  endtask

  task automatic test_basic();
    int s, od, na;
    q0 = '{8'sd1, 8'sd3, 8'sd5};
    q1 = '{8'sd2, 8'sd4, 8'sd6};
    run_tile(3, 0, -1, s, od, na);
    checks++;
    if (od - s != 8) begin
      errors++; $display("FAIL basic_done_time got=%0d exp=8", od - s);
    end
  endtask

  task automatic test_bubble();
    int s, od, na;
    q0 = '{-8'sd7, 8'sd100};
    q1 = '{8'sd9, -8'sd128};
    run_tile(2, 2, -1, s, od, na);
    checks++;
    if (na != 2 || od - s != 2 + 1 + 2 + D) begin
      errors++; $display("FAIL bubble_accepts got=%0d/%0d exp=2/%0d", na, od - s, 5 + D);
    end
  endtask

  task automatic test_zero_count();
    start = 1'b1; vec_count = '0; in_valid = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || r0v !== 1'b0 || r1v !== 1'b0) begin
      errors++; $display("FAIL zero_done got=%b%b%b%b%b exp=10000", done, busy, in_ready, r0v, r1v);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || r0v !== 1'b0 || r1v !== 1'b0) begin
      errors++; $display("FAIL zero_after got=%b%b%b%b exp=0000", done, busy, r0v, r1v);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    int s, od, na;
    start = 1'b1; vec_count = CW'(4);
    step();
    start = 1'b0; in_valid = 1'b1; in_row0 = 8'sd11; in_row1 = 8'sd22;
    step();
    checks++;
    if (r0v !== 1'b1 || r0 !== 8'sd11) begin
      errors++; $display("FAIL abort_first got=%b/%0d exp=1/11", r0v, r0);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if ({r0v, r1v, in_ready, busy, done} !== 5'b0 || r0 !== 0 || r1 !== 0) begin
      errors++; $display("FAIL abort_clear got=%b%b%b%b%b r0=%0d r1=%0d exp=00000 0 0", r0v, r1v, in_ready, busy, done, r0, r1);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || in_ready !== 1'b0 || r0v !== 1'b0) begin
        errors++; $display("FAIL abort_quiet cyc=%0d got=%b%b%b exp=000", cyc, done, in_ready, r0v);
      end
    end
    in_valid = 1'b0;
    run_tile(2, 0, -1, s, od, na);
  endtask

  task automatic test_ignored_start();
    int s, od, na;
    run_tile(2, 0, 0, s, od, na);
    checks++;
    if (na != 2 || od - s != 2 + 2 + D) begin
      errors++; $display("FAIL ignored_start got=%0d/%0d exp=2/%0d", na, od - s, 4 + D);
    end
  endtask

  task automatic test_back_to_back();
    int s, od, na;
    for (int i = 0; i < 8; i++) run_tile($urandom_range(1, 6), 1, -1, s, od, na);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_zero_count();
    test_abort();
    test_ignored_start();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input-side skew generator for the 2x2 systolic MMU; it is the counterpart of the accumulator's deskew stage. It accepts unskewed 2-element activation vectors from the unified-buffer read path under a valid/ready handshake. It drives MMU row 0 immediately and row 1 one cycle later, producing the diagonal wavefront the array expects. It sequences one tile of N vectors per `start`, then flushes the skew and array pipeline before pulsing `done`.

## Interface
- `DATA_W`, 8: width of each signed activation element.
- `CNT_W`, 8: width of the vector-count field.
- `DRAIN_CYCLES`, 3: idle cycles after the last row-1 output before `done`; covers array propagation.
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `clear`  in  1  synchronous abort; returns to IDLE and zeroes outputs; no `done`.
- `start`  in  1  one-cycle pulse that begins a tile; ignored unless in IDLE.
- `vec_count`  in  CNT_W  number of vectors in the tile; sampled when `start` is accepted.
- `in_valid`  in  1  upstream vector valid.
- `in_ready`  out  1  feeder can accept a vector this cycle.
- `in_row0`, `in_row1`  in  DATA_W each, signed  activation elements of one vector.
- `mmu_row0_out`, `mmu_row1_out`  out  DATA_W each, signed  registered MMU row inputs.
- `mmu_row0_valid`, `mmu_row1_valid`  out  1 each  per-row data valid.
- `busy`  out  1  high in FEED, SKEW and DRAIN.
- `done`  out  1  one-cycle pulse at tile completion.

## Operation
- The FSM has four states: IDLE, FEED, SKEW and DRAIN.
- IDLE: `in_ready`=0.
  - `start` with `vec_count`>0 latches the count, clears the accept counter and goes to FEED.
  - `start` with `vec_count`=0 pulses `done` on the next cycle and stays in IDLE.
- FEED: `in_ready`=1 while accepted < count.
  - A vector is accepted on a cycle where `in_valid`&&`in_ready`.
  - On the accept of the final vector, the FSM goes to SKEW.
- SKEW: lasts one cycle so the final row-1 element is emitted. It then goes to DRAIN with the drain counter set to DRAIN_CYCLES.
- DRAIN: decrements each cycle. At 0, or immediately if DRAIN_CYCLES=0, it asserts `done` for one cycle and returns to IDLE.
- Row 0 path: on an accept, `mmu_row0_out`<=`in_row0` and `mmu_row0_valid`<=1. Otherwise `mmu_row0_out`<=0 and `mmu_row0_valid`<=0.
- Row 1 path: an internal one-deep stage captures `in_row1` and the accept flag on each accept. Its contents move to `mmu_row1_out` and `mmu_row1_valid` on the following edge. When there is no accept, zero and valid=0 propagate the same way.
- Upstream bubbles: an `in_valid` low cycle in FEED produces a zero/invalid slot on row 0, then on row 1 one cycle later. The skew relationship is always preserved.
- Data passes through unmodified. There is no arithmetic and no sign extension.
- `clear` has priority over `start` and over all state transitions. It zeroes the outputs, the skew stage and the counters, and forces IDLE.
- `start` in a non-IDLE state is ignored and does not change the latched count.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0, all `mmu_*` outputs=0, state=IDLE.
- Accept at edge k:
  - Row 0 is visible on the outputs after edge k.
  - Row 1 is visible after edge k+1, exactly one cycle later.
- `in_ready` is combinational from state and counter only. It does not depend on `in_valid`.
- `in_ready` is high in the first cycle after `start` is accepted.
- Full tile with no bubbles, `start` at edge s, N vectors:
  - Accepts occur at edges s+1 … s+N.
  - The final row-1 valid appears after edge s+N+1.
  - `done` is high in the cycle after edge s+N+2+DRAIN_CYCLES.
- `busy` rises after the `start` edge and falls in the same cycle that `done` is asserted.
- `done` never coincides with `mmu_row*_valid`=1.
- Asynchronous `reset` mid-tile takes effect immediately. After release, the block waits for a new `start`.

## Test plan
- Reset: assert `reset` mid-FEED → all outputs 0 and `in_ready`=0 immediately; the block is idle after release.
- Basic tile: `vec_count`=3, vectors (1,2), (3,4), (5,6) with continuous `in_valid` → row 0 outputs 1,3,5 on cycles s+1..s+3; row 1 outputs 2,4,6 on cycles s+2..s+4; with DRAIN_CYCLES=3, `done` at s+8.
- Bubble: `vec_count`=2, vector (−7,9), one `in_valid`=0 cycle, then (100,−128) → row 0 outputs −7, 0(invalid), 100; row 1 outputs 9, 0(invalid), −128, each one cycle after row 0; 2 accepts total.
- Zero count: `start` with `vec_count`=0 → `done` the next cycle; `busy` stays 0; no valid outputs.
- Abort: `clear` after 1 of 4 accepts → outputs zero the next cycle, `in_ready`=0, no `done`; a following `start` with count 2 runs cleanly.
- Ignored start: pulse `start` with `vec_count`=9 during FEED of a 2-vector tile → exactly 2 accepts, and `done` at nominal timing.
